// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 1-bit ALU and its serial sequencer.
//   alu_op_e   : 2-bit ALU operation encoding (AND/OR/XOR/NAND)
//   state_e    : sequencer FSM state encoding
//   cnt_width  : width of the bit-index counter for a given word width
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_AND  = 2'b00,
    ALU_OR   = 2'b01,
    ALU_XOR  = 2'b10,
    ALU_NAND = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  // A 1-bit word still needs a 1-bit counter, because $clog2(1) is 0.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/alu_seq_cnt.sv
// ---------------------------------------------------------------------------
// alu_seq_cnt
// Bit-index counter for the serial sequencer. Counts 0..WIDTH-1 while
// enabled and wraps back to 0 after the terminal count.
// Ports:
//   clk_i  in   1      clock, rising edge
//   rst_i  in   1      synchronous reset, active-high
//   clr_i  in   1      synchronous clear to 0
//   en_i   in   1      advance the count
//   cnt_o  out  CW     current bit index
//   tc_o   out  1      high while cnt_o == WIDTH-1
// ---------------------------------------------------------------------------
module alu_seq_cnt #(
  parameter int WIDTH = 8,
  parameter int CW    = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q;

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == CW'(WIDTH - 1));

  // Wrapping on the terminal count leaves the index at 0 for the next word,
  // so the counter needs no separate clear when the word finishes.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tc_o ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/alu_serial_seq.sv
// ---------------------------------------------------------------------------
// alu_serial_seq
// Upstream sequencer for an external combinational 1-bit ALU. Accepts a
// WIDTH-bit operand pair plus op, feeds the ALU one bit per clock (LSB
// first), collects the result bits into a word and offers that word
// downstream with a valid/ready handshake.
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      operand word valid
//   in_ready   out  1      word can be accepted (IDLE only)
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_op      in   2      ALU op (alu_pkg::alu_op_e encoding)
//   alu_a      out  1      current bit of A to the ALU
//   alu_b      out  1      current bit of B to the ALU
//   alu_ctrl   out  2      op to the ALU
//   alu_res    in   1      ALU result bit, sampled in the same cycle
//   out_valid  out  1      result word valid
//   out_ready  in   1      downstream accepts the result
//   out_res    out  WIDTH  assembled result word
//   out_zero   out  1      (ALU_SEQ_ZFLAG_EN only) out_res == 0, valid with out_valid
// Configuration macro: ALU_SEQ_ZFLAG_EN adds the out_zero flag.
// ---------------------------------------------------------------------------
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             alu_a,
  output logic             alu_b,
  output logic [1:0]       alu_ctrl,
  input  logic             alu_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res
`ifdef ALU_SEQ_ZFLAG_EN
  ,
  output logic             out_zero
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [CW-1:0]    cnt;
  logic             cnt_tc;
  logic             accept;
  logic             shifting;

  assign accept   = (state_q == S_IDLE) && in_valid && in_ready_q;
  assign shifting = (state_q == S_SHIFT);

  alu_seq_cnt #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (accept),
    .en_i  (shifting),
    .cnt_o (cnt),
    .tc_o  (cnt_tc)
  );

  // The ALU is purely combinational, so its operand bits come straight from
  // the latched words; outside SHIFT they are forced low and the op is held.
  assign alu_a    = shifting ? a_q[cnt] : 1'b0;
  assign alu_b    = shifting ? b_q[cnt] : 1'b0;
  assign alu_ctrl = op_q;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_res   = res_q;

  // Result word with the current ALU bit merged in; it is also the final
  // word on the last SHIFT cycle, which lets the zero flag be registered
  // together with the DONE transition.
  always_comb begin
    res_d      = res_q;
    res_d[cnt] = alu_res;
  end

  // Single FSM: IDLE accepts a word, SHIFT runs WIDTH bit cycles, DONE holds
  // the word until the downstream handshake. in_ready and out_valid are
  // registered alongside the state so they always match it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 2'b00;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q        <= in_a;
            b_q        <= in_b;
            op_q       <= in_op;
            res_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          res_q <= res_d;
          if (cnt_tc) begin
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          // Returning to IDLE here, with in_ready raised a cycle later,
          // keeps an accept from coinciding with the result handshake.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_ZFLAG_EN
  logic zero_q;

  assign out_zero = zero_q;

  // Captured from the completed word on the last bit cycle so it is valid
  // exactly when out_valid rises; cleared when a new word is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (accept) begin
      zero_q <= 1'b0;
    end else if (shifting && cnt_tc) begin
      zero_q <= ~|res_d;
    end
  end
`endif

endmodule
